// File: rtl/bf_syndrome_sched_if.sv
// ---------------------------------------------------------------------------
// bf_syndrome_sched_if
//
// Purpose: bundles every handshake and data signal of the bit-flipping LDPC
// iteration controller. The controller connects through the slave modport.
// The decoder core, the shared popcount adder and a testbench drive the
// master side.
//
// Signals (direction seen from the controller):
//   start       in   one-cycle pulse that begins a decode
//   syn_in      in   N_SYN-bit syndrome from the decoder core
//   syn_valid   in   syn_in valid
//   syn_ready   out  controller is waiting for a syndrome
//   add_data    out  CHUNK-bit slice fed to the shared popcount adder
//   add_sum     in   adder result, combinational in the same cycle
//   flip_req    out  request one flip iteration (held until flip_ack)
//   flip_ack    in   decoder core finished the flip iteration
//   done        out  one-cycle pulse at the end of a decode
//   success     out  final syndrome weight was zero
//   stall       out  decode was ended by stall detection
//   iter_cnt    out  flip iterations performed
//   syn_weight  out  weight from the most recent summation
// ---------------------------------------------------------------------------
interface bf_syndrome_sched_if #(
    parameter int N_SYN     = 1024,
    parameter int CHUNK     = 256,
    parameter int ADD_BITS  = 9,
    parameter int W_BITS    = 11,
    parameter int ITER_BITS = 5
);
    logic                 start;
    logic [N_SYN-1:0]     syn_in;
    logic                 syn_valid;
    logic                 syn_ready;
    logic [CHUNK-1:0]     add_data;
    logic [ADD_BITS-1:0]  add_sum;
    logic                 flip_req;
    logic                 flip_ack;
    logic                 done;
    logic                 success;
    logic                 stall;
    logic [ITER_BITS-1:0] iter_cnt;
    logic [W_BITS-1:0]    syn_weight;

    // Controller side
    modport slave (
        input  start, syn_in, syn_valid, add_sum, flip_ack,
        output syn_ready, add_data, flip_req, done, success, stall,
               iter_cnt, syn_weight
    );

    // Decoder core / adder / testbench side
    modport master (
        output start, syn_in, syn_valid, add_sum, flip_ack,
        input  syn_ready, add_data, flip_req, done, success, stall,
               iter_cnt, syn_weight
    );
endinterface

// File: rtl/bf_syndrome_sched.sv
// ---------------------------------------------------------------------------
// bf_syndrome_sched
//
// Purpose: iteration controller for the bit-flipping LDPC decoder. Each
// iteration it latches the syndrome and runs it through one shared
// CHUNK-bit popcount adder, one chunk per cycle, to get the syndrome weight.
// It then ends the decode (converged or out of iterations) or asks the
// decoder core for another flip iteration.
//
// Ports:
//   clk  system clock (single domain)
//   rst  synchronous, active-high reset; aborts a decode without done
//   bus  bf_syndrome_sched_if.slave (see the interface file for signals)
//
// Configuration macro:
//   BF_STALL_DETECT_EN  when defined, the decode also ends (success=0,
//                       stall=1) if the weight did not drop since the
//                       previous iteration. When undefined, stall is tied 0.
// ---------------------------------------------------------------------------
module bf_syndrome_sched #(
    parameter int N_SYN     = 1024,
    parameter int CHUNK     = 256,
    parameter int ADD_BITS  = 9,
    parameter int W_BITS    = 11,
    parameter int MAX_ITER  = 20,
    parameter int ITER_BITS = 5
) (
    input logic             clk,
    input logic             rst,
    bf_syndrome_sched_if.slave bus
);

    localparam int NUM_CHUNKS = N_SYN / CHUNK;
    localparam int K_BITS     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYN,
        S_SUM,
        S_DECIDE,
        S_FLIP,
        S_DONE
    } state_t;

    state_t               state_q,    state_d;
    logic [N_SYN-1:0]     syn_q,      syn_d;
    logic [W_BITS-1:0]    acc_q,      acc_d;
    logic [K_BITS-1:0]    k_q,        k_d;
    logic [ITER_BITS-1:0] iter_q,     iter_d;
    logic [W_BITS-1:0]    weight_q,   weight_d;
    logic                 success_q,  success_d;
    logic                 done_q,     done_d;
    logic                 flip_req_q, flip_req_d;
`ifdef BF_STALL_DETECT_EN
    logic [W_BITS-1:0]    prev_q,     prev_d;
    logic                 stall_q,    stall_d;
`endif

    logic [ADD_BITS-1:0]  add_sum_w;
    logic [CHUNK-1:0]     add_data_w;

    assign add_sum_w = bus.add_sum;

    // The adder sees the chunk selected by k only while summing; all other
    // states present zero so the shared adder is left idle.
    always_comb begin
        add_data_w = '0;
        if (state_q == S_SUM) begin
            add_data_w = syn_q[k_q*CHUNK +: CHUNK];
        end
    end

    // Next-state and next-output computation for the whole controller.
    // done and flip_req are decided one cycle ahead so that they come
    // straight out of flops.
    always_comb begin
        state_d    = state_q;
        syn_d      = syn_q;
        acc_d      = acc_q;
        k_d        = k_q;
        iter_d     = iter_q;
        weight_d   = weight_q;
        success_d  = success_q;
        done_d     = 1'b0;
        flip_req_d = flip_req_q;
`ifdef BF_STALL_DETECT_EN
        prev_d     = prev_q;
        stall_d    = stall_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    iter_d    = '0;
                    success_d = 1'b0;
                    weight_d  = '0;
`ifdef BF_STALL_DETECT_EN
                    stall_d   = 1'b0;
`endif
                    state_d   = S_WAIT_SYN;
                end
            end

            S_WAIT_SYN: begin
                if (bus.syn_valid) begin
                    syn_d   = bus.syn_in;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_SUM;
                end
            end

            S_SUM: begin
                acc_d = acc_q + W_BITS'(add_sum_w);
                if (k_q == K_BITS'(NUM_CHUNKS - 1)) begin
                    state_d = S_DECIDE;
                end else begin
                    k_d = k_q + K_BITS'(1);
                end
            end

            // Rule order matters: convergence first, then stall (when
            // enabled), then the iteration limit.
            S_DECIDE: begin
                weight_d = acc_q;
`ifdef BF_STALL_DETECT_EN
                prev_d   = acc_q;
`endif
                if (acc_q == '0) begin
                    success_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
`ifdef BF_STALL_DETECT_EN
                end else if ((iter_q != '0) && (acc_q >= prev_q)) begin
                    stall_d   = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
`endif
                end else if (iter_q == ITER_BITS'(MAX_ITER)) begin
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    flip_req_d = 1'b1;
                    state_d    = S_FLIP;
                end
            end

            S_FLIP: begin
                if (bus.flip_ack) begin
                    flip_req_d = 1'b0;
                    iter_d     = iter_q + ITER_BITS'(1);
                    state_d    = S_WAIT_SYN;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All controller state is registered here. Reset clears everything, so
    // an abort mid-decode never produces a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            syn_q      <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            iter_q     <= '0;
            weight_q   <= '0;
            success_q  <= 1'b0;
            done_q     <= 1'b0;
            flip_req_q <= 1'b0;
`ifdef BF_STALL_DETECT_EN
            prev_q     <= '0;
            stall_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            syn_q      <= syn_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            iter_q     <= iter_d;
            weight_q   <= weight_d;
            success_q  <= success_d;
            done_q     <= done_d;
            flip_req_q <= flip_req_d;
`ifdef BF_STALL_DETECT_EN
            prev_q     <= prev_d;
            stall_q    <= stall_d;
`endif
        end
    end

    assign bus.syn_ready  = (state_q == S_WAIT_SYN);
    assign bus.add_data   = add_data_w;
    assign bus.flip_req   = flip_req_q;
    assign bus.done       = done_q;
    assign bus.success    = success_q;
    assign bus.iter_cnt   = iter_q;
    assign bus.syn_weight = weight_q;
`ifdef BF_STALL_DETECT_EN
    assign bus.stall      = stall_q;
`else
    assign bus.stall      = 1'b0;
`endif

endmodule

// File: tb/tb_bf_syndrome_sched.sv
// ---------------------------------------------------------------------------
// tb_bf_syndrome_sched
//
// Testbench for bf_syndrome_sched. A driver runs whole decodes. For each
// decode it pre-builds the sequence of syndromes and predicts the outcome
// from the decode rules (popcount, convergence, stall, iteration limit).
// A monitor checks the adder chunks, flip handshakes, latency and the final
// result. If BF_STALL_DETECT_EN is defined for this build, the reference
// model includes the stall rule as well.
// ---------------------------------------------------------------------------
module tb_bf_syndrome_sched;

    localparam int N_SYN      = 1024;
    localparam int CHUNK      = 256;
    localparam int ADD_BITS   = 9;
    localparam int W_BITS     = 11;
    localparam int MAX_ITER   = 20;
    localparam int ITER_BITS  = 5;
    localparam int NUM_CHUNKS = N_SYN / CHUNK;

    typedef struct {
        bit success;
        bit stall;
        int iter;
        int weight;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    exp_t             exp_q[$];
    logic [CHUNK-1:0] chunk_q[$];
    logic [N_SYN-1:0] syn_list[$];

    bf_syndrome_sched_if #(
        .N_SYN(N_SYN), .CHUNK(CHUNK), .ADD_BITS(ADD_BITS),
        .W_BITS(W_BITS), .ITER_BITS(ITER_BITS)
    ) bus ();

    bf_syndrome_sched #(
        .N_SYN(N_SYN), .CHUNK(CHUNK), .ADD_BITS(ADD_BITS),
        .W_BITS(W_BITS), .MAX_ITER(MAX_ITER), .ITER_BITS(ITER_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // The shared popcount adder, modelled as a combinational count of ones.
    assign bus.add_sum = ADD_BITS'($countones(bus.add_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Safety net so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one value and updates the counters.
    task automatic checkOutput(input string name, input logic [CHUNK-1:0] act,
                               input logic [CHUNK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cycle);
        end
    endtask

    // Random syndrome with exactly w ones.
    function automatic logic [N_SYN-1:0] make_syn(input int w);
        logic [N_SYN-1:0] v;
        int cnt;
        int p;
        v   = '0;
        cnt = 0;
        if (w >= N_SYN) return '1;
        while (cnt < w) begin
            p = $urandom_range(N_SYN - 1, 0);
            if (!v[p]) begin
                v[p] = 1'b1;
                cnt++;
            end
        end
        return v;
    endfunction

    // Outcome of a decode, derived from the list of syndromes the core will
    // deliver on successive iterations.
    function automatic exp_t model();
        exp_t e;
        int   w;
        int   prev;
        e.success = 1'b0;
        e.stall   = 1'b0;
        e.iter    = 0;
        e.weight  = 0;
        prev      = 0;
        for (int i = 0; i < syn_list.size(); i++) begin
            w        = $countones(syn_list[i]);
            e.weight = w;
            e.iter   = i;
            if (w == 0) begin
                e.success = 1'b1;
                return e;
            end
`ifdef BF_STALL_DETECT_EN
            if (i > 0 && w >= prev) begin
                e.stall = 1'b1;
                return e;
            end
`endif
            if (i == MAX_ITER) return e;
            prev = w;
        end
        return e;
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one full decode. kind selects the syndrome sequence; ack_delay
    // is the number of cycles flip_ack lags flip_req (-1 = random 0..7).
    task automatic applyStimulus(input int kind, input int ack_delay);
        exp_t             e;
        logic [N_SYN-1:0] v;
        int               found;
        int               n;
        int               d;

        syn_list.delete();
        case (kind)
            0: syn_list.push_back('0);
            1: begin
                v = '0;
                for (int i = 0; i < 134; i++) v[i] = 1'b1;
                v[N_SYN-1] = 1'b1;
                syn_list.push_back(v);
                syn_list.push_back('0);
            end
            2: for (int i = 0; i <= MAX_ITER; i++) syn_list.push_back(make_syn(5));
            3: begin
                syn_list.push_back('1);
                syn_list.push_back('0);
            end
            4: begin
                syn_list.push_back(make_syn(10));
                syn_list.push_back(make_syn(8));
                syn_list.push_back(make_syn(8));
                syn_list.push_back(make_syn(5));
                syn_list.push_back('0);
            end
            default: begin
                if ($urandom_range(3, 0) == 0) begin
                    for (int i = 0; i <= MAX_ITER; i++)
                        syn_list.push_back(make_syn($urandom_range(300, 1)));
                end else begin
                    n = $urandom_range(5, 0);
                    for (int i = 0; i < n; i++)
                        syn_list.push_back(make_syn($urandom_range(40, 1)));
                    syn_list.push_back('0);
                end
            end
        endcase
        e = model();
        exp_q.push_back(e);

        // Start; sometimes with a junk syndrome that must not be latched.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.syn_valid = ($urandom_range(1, 0) == 1);
        bus.syn_in    = make_syn(77);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.syn_valid = 1'b0;

        for (int idx = 0; idx < syn_list.size(); idx++) begin
            found = 0;
            for (int t = 0; t < 8 && !bus.syn_ready; t++) @(negedge clk);
            repeat ($urandom_range(2, 0)) @(negedge clk);
            bus.syn_in    = syn_list[idx];
            bus.syn_valid = 1'b1;
            @(negedge clk);
            bus.syn_valid = 1'b0;
            for (int t = 0; t < 12 && found == 0; t++) begin
                if (bus.done) begin
                    found = 2;
                end else if (bus.flip_req) begin
                    found = 1;
                end else begin
                    // Stray acknowledges outside FLIP must be ignored.
                    bus.flip_ack = ($urandom_range(3, 0) == 0);
                    @(negedge clk);
                    bus.flip_ack = 1'b0;
                end
            end
            if (found == 0) begin
                checkOutput("decode_progress_timeout", 0, 1);
                doReset();
                return;
            end
            if (found == 2) return;
            d = (ack_delay < 0) ? $urandom_range(7, 0) : ack_delay;
            repeat (d) @(negedge clk);
            bus.flip_ack = 1'b1;
            @(negedge clk);
            bus.flip_ack = 1'b0;
        end
        checkOutput("decode_no_done", 0, 1);
        doReset();
    endtask

    // Starts a decode and resets while it is summing.
    task automatic applyMidReset();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 0; t < 8 && !bus.syn_ready; t++) @(negedge clk);
        bus.syn_in    = make_syn(50);
        bus.syn_valid = 1'b1;
        @(negedge clk);
        bus.syn_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_add_data",   bus.add_data,   0);
        checkOutput("rst_done",       bus.done,       0);
        checkOutput("rst_success",    bus.success,    0);
        checkOutput("rst_stall",      bus.stall,      0);
        checkOutput("rst_iter_cnt",   bus.iter_cnt,   0);
        checkOutput("rst_syn_weight", bus.syn_weight, 0);
        checkOutput("rst_flip_req",   bus.flip_req,   0);
        checkOutput("rst_syn_ready",  bus.syn_ready,  0);
        repeat (12) @(negedge clk);
    endtask

    // Monitor: samples just after each falling edge, so inputs driven at
    // that edge are the ones the next rising edge will see.
    initial begin : monitor
        logic [CHUNK-1:0] ec;
        exp_t e;
        int   acc_cycle;
        int   last_w;
        int   hs_count;
        bit   prev_req;
        bit   req_pending;
        bit   ack_seen;
        bit   prev_done;
        acc_cycle   = 0;
        last_w      = 0;
        hs_count    = 0;
        prev_req    = 0;
        req_pending = 0;
        ack_seen    = 0;
        prev_done   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (chunk_q.size() > 0) begin
                ec = chunk_q.pop_front();
                checkOutput("add_data_chunk", bus.add_data, ec);
            end else begin
                checkOutput("add_data_idle", bus.add_data, 0);
            end
            if (rst) begin
                chunk_q.delete();
                exp_q.delete();
                hs_count    = 0;
                prev_req    = 0;
                req_pending = 0;
                ack_seen    = 0;
                prev_done   = 0;
            end else begin
                if (req_pending) checkOutput("flip_req_held", bus.flip_req, 1);
                if (ack_seen)    checkOutput("flip_req_drop", bus.flip_req, 0);
                if (prev_done)   checkOutput("done_one_cycle", bus.done, 0);
                if (bus.flip_req && !prev_req) begin
                    checkOutput("flip_req_latency", cycle - acc_cycle, 6);
                    checkOutput("flip_weight", bus.syn_weight, last_w);
                    checkOutput("flip_stall", bus.stall, 0);
                end
                ack_seen    = bus.flip_req && bus.flip_ack;
                if (ack_seen) hs_count++;
                req_pending = bus.flip_req && !bus.flip_ack;
                prev_req    = bus.flip_req;
                prev_done   = bus.done;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("done_latency", cycle - acc_cycle, 6);
                        checkOutput("success",      bus.success,    e.success);
                        checkOutput("stall",        bus.stall,      e.stall);
                        checkOutput("iter_cnt",     bus.iter_cnt,   e.iter);
                        checkOutput("syn_weight",   bus.syn_weight, e.weight);
                        checkOutput("flip_handshakes", hs_count,    e.iter);
                        checkOutput("flip_req_at_done", bus.flip_req, 0);
                    end
                    hs_count = 0;
                end
                if (bus.syn_valid && bus.syn_ready) begin
                    acc_cycle = cycle;
                    last_w    = $countones(bus.syn_in);
                    for (int k = 0; k < NUM_CHUNKS; k++)
                        chunk_q.push_back(bus.syn_in[k*CHUNK +: CHUNK]);
                end
            end
        end
    end

    initial begin : driver
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.syn_in    = '0;
        bus.syn_valid = 1'b0;
        bus.flip_ack  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("init_done",       bus.done,       0);
        checkOutput("init_flip_req",   bus.flip_req,   0);
        checkOutput("init_syn_ready",  bus.syn_ready,  0);
        checkOutput("init_iter_cnt",   bus.iter_cnt,   0);
        checkOutput("init_syn_weight", bus.syn_weight, 0);
        checkOutput("init_success",    bus.success,    0);
        checkOutput("init_stall",      bus.stall,      0);
        rst = 1'b0;

        applyStimulus(0, -1);
        applyStimulus(1, 2);
        applyStimulus(2, 2);
        applyStimulus(3, -1);
        applyStimulus(4, -1);
        applyMidReset();
        applyStimulus(1, 7);
        for (int i = 0; i < 10; i++) applyStimulus(5, -1);
        applyStimulus(0, -1);

        repeat (10) @(negedge clk);
        checkOutput("outstanding_expected", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
